// File: rtl/rsp_fifo_uart_tx_if.sv
// Response FIFO read port: empty flag, read data and a single-cycle read enable.
interface rsp_fifo_uart_tx_if;
    logic        rsp_fifo_empty;
    logic [31:0] rsp_fifo_data;
    logic        rsp_fifo_read;

    modport master (
        input  rsp_fifo_empty,
        input  rsp_fifo_data,
        output rsp_fifo_read
    );

    modport slave (
        output rsp_fifo_empty,
        output rsp_fifo_data,
        input  rsp_fifo_read
    );
endinterface

// File: rtl/rsp_fifo_uart_tx.sv
// Pops 32-bit response words from a FIFO and sends them MSB byte first as 8N1 UART,
// optionally dropping 8'h00 bytes.
module rsp_fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter bit          SKIP_NULL    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    rsp_fifo_uart_tx_if.master   fifo,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 word_done
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        read_q, read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  cur_byte;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd3:    byte_sel = w[31:24];
            2'd2:    byte_sel = w[23:16];
            2'd1:    byte_sel = w[15:8];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign cur_byte = byte_sel(word_q, idx_q[1:0]);

    // idx_q[2] set means the index has run past byte 0 and the word is finished.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        word_d  = word_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        read_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo.rsp_fifo_empty) begin
                    read_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: state_d = S_LOAD;
            S_LOAD: begin
                word_d  = fifo.rsp_fifo_data;
                idx_d   = 3'd3;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q[2]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (SKIP_NULL && (cur_byte == 8'h00)) begin
                    idx_d = idx_q - 3'd1;
                end else begin
                    shift_d = cur_byte;
                    tx_d    = 1'b0;
                    cnt_d   = BIT_LAST;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (cnt_q == 16'd0) begin
                    cnt_d   = BIT_LAST;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == 16'd0) begin
                    cnt_d = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = BIT_LAST;
                    idx_d   = idx_q - 3'd1;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            idx_q   <= 3'd0;
            word_q  <= 32'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo.rsp_fifo_read = read_q;
    assign uart_tx            = tx_q;
    assign busy               = busy_q;
    assign word_done          = done_q;

endmodule

// File: tb/tb_rsp_fifo_uart_tx.sv
// Directed bench for rsp_fifo_uart_tx at CLKS_PER_BIT=4 with a two-cycle-latency FIFO model
// and a cycle-sampled UART receiver.
module tb_rsp_fifo_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_tx, busy, word_done;

    rsp_fifo_uart_tx_if fifo ();

    rsp_fifo_uart_tx #(.CLKS_PER_BIT(CPB), .SKIP_NULL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo      (fifo),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on the second rising edge after the read-enable cycle.
    logic [31:0] mem [16];
    int   wr_ptr  = 0;
    int   rd_ptr  = 0;
    logic rd_pend = 1'b0;
    int   cyc     = 0;

    assign fifo.rsp_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= 1'b0;
        if (fifo.rsp_fifo_read && (rd_ptr != wr_ptr)) begin
            rd_pend <= 1'b1;
            rd_ptr  <= rd_ptr + 1;
        end
        if (rd_pend) fifo.rsp_fifo_data <= mem[4'(rd_ptr - 1)];
    end

    int         low_cnt = 0;
    int         frm_err = 0;
    int         rd_cyc [$];
    int         wd_cyc [$];
    logic [7:0] rx_b   [$];
    int         rx_st  [$];

    initial begin : mon
        int         rc;
        logic       act;
        logic [7:0] sh;
        act = 1'b0;
        rc  = 0;
        sh  = 8'h00;
        forever begin
            @(negedge clk);
            if (fifo.rsp_fifo_read === 1'b1) rd_cyc.push_back(cyc);
            if (word_done === 1'b1) wd_cyc.push_back(cyc);
            if (uart_tx !== 1'b1) low_cnt++;
            if (reset === 1'b0) begin
                act = 1'b0;
            end else if (!act) begin
                if (uart_tx === 1'b0) begin
                    act = 1'b1;
                    rc  = 0;
                    rx_st.push_back(cyc);
                end
            end else begin
                rc++;
                if (rc == 2 && uart_tx !== 1'b0) frm_err++;
                if (rc >= 6 && rc <= 34 && (rc % 4) == 2) sh = {uart_tx, sh[7:1]};
                if (rc == 38) begin
                    if (uart_tx !== 1'b1) frm_err++;
                    rx_b.push_back(sh);
                    act = 1'b0;
                end
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wd(input int n, input int budget);
        int k = 0;
        while (wd_cyc.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("word_done_count", wd_cyc.size(), n);
    endtask

    task automatic wait_rd(input int n, input int budget);
        int k = 0;
        while (rd_cyc.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("read_count", rd_cyc.size(), n);
    endtask

    logic [7:0] exp_ack [4] = '{8'h41, 8'h43, 8'h4B, 8'h0A};
    logic [7:0] exp_two [8] = '{8'h4E, 8'h41, 8'h4B, 8'h0A, 8'h30, 8'h2E, 8'h31, 8'h0A};

    initial begin
        int b, s, lsnap, rsnap;

        // Reset held with a word already waiting in the FIFO.
        mem[0] = 32'h41434B0A;
        wr_ptr = 1;
        reset  = 1'b0;
        repeat (3) begin
            step();
            chk("rst_tx",   32'(uart_tx), 32'd1);
            chk("rst_read", 32'(fifo.rsp_fifo_read), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(word_done), 32'd0);
        end
        reset = 1'b1;

        // "ACK\n"
        wait_wd(1, 400);
        chk("ack_reads", rd_cyc.size(), 1);
        chk("ack_nbytes", rx_b.size(), 4);
        for (int i = 0; i < 4; i++) chk("ack_byte", 32'(rx_b[i]), 32'(exp_ack[i]));
        chk("ack_first_start", rx_st[0] - rd_cyc[0], 4);
        for (int i = 1; i < 4; i++) chk("ack_spacing", rx_st[i] - rx_st[i-1], 41);
        chk("ack_done_lat", wd_cyc[0] - rx_st[3], 41);
        step();
        chk("ack_idle_busy", 32'(busy), 32'd0);

        // Nulls interleaved with data.
        b = rx_b.size();
        s = rx_st.size();
        mem[1] = 32'h0031000A;
        wr_ptr = 2;
        wait_wd(2, 400);
        chk("skip_nbytes", rx_b.size() - b, 2);
        chk("skip_byte0", 32'(rx_b[b]), 32'h31);
        chk("skip_byte1", 32'(rx_b[b+1]), 32'h0A);
        chk("skip_first_start", rx_st[s] - rd_cyc[1], 5);
        chk("skip_spacing", rx_st[s+1] - rx_st[s], 42);

        // All-zero word: no start bit at all.
        b      = rx_b.size();
        lsnap  = low_cnt;
        mem[2] = 32'h00000000;
        wr_ptr = 3;
        wait_wd(3, 100);
        chk("zero_nbytes", rx_b.size() - b, 0);
        chk("zero_line_low", low_cnt - lsnap, 0);
        chk("zero_done_lat", wd_cyc[2] - rd_cyc[2], 8);

        // Two words queued back to back.
        b      = rx_b.size();
        mem[3] = 32'h4E414B0A;
        mem[4] = 32'h302E310A;
        wr_ptr = 5;
        wait_wd(5, 1000);
        chk("two_reads", rd_cyc.size(), 5);
        chk("two_read_after_done", rd_cyc[4] - wd_cyc[3], 1);
        chk("two_nbytes", rx_b.size() - b, 8);
        for (int i = 0; i < 8; i++) chk("two_byte", 32'(rx_b[b+i]), 32'(exp_two[i]));
        chk("frame_errors", frm_err, 0);

        // Abort in data bit 1 of 0x41 (bit value 0).
        mem[5] = 32'h41434B0A;
        wr_ptr = 6;
        wait_rd(6, 50);
        repeat (13) step();
        chk("abort_pre_tx", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        step();
        chk("abort_tx",   32'(uart_tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_read", 32'(fifo.rsp_fifo_read), 32'd0);
        step();
        reset = 1'b1;
        lsnap = low_cnt;
        rsnap = rd_cyc.size();
        repeat (60) step();
        chk("post_abort_reads", rd_cyc.size() - rsnap, 0);
        chk("post_abort_low", low_cnt - lsnap, 0);
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_done", wd_cyc.size(), 5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
